// File: rtl/ascii2ps2_seq_if.sv
// Signal bundle between the keystroke encoder, its ASCII source and the PS/2 byte sink.
interface ascii2ps2_seq_if #(parameter int FIFO_DEPTH = 32);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  ascii;
    logic        latch;
    logic        in_ready;
    logic [7:0]  scancode;
    logic        valid;
    logic        ready;
    logic        shift_held;
    logic        overflow;
    logic [AW:0] level;
    logic [3:0]  dbg_state;

    // Output handshake: a byte moves on a clock edge where valid && ready; once valid is high, scancode holds until that edge.
    modport master (output ascii, latch, ready,
                    input  in_ready, scancode, valid, shift_held, overflow, level, dbg_state);
    modport slave  (input  ascii, latch, ready,
                    output in_ready, scancode, valid, shift_held, overflow, level, dbg_state);
endinterface

// File: rtl/ascii2ps2_seq.sv
// ASCII character to PS/2 set-2 make/break byte sequence encoder with a scancode FIFO
// and a valid/ready output register; sits between the UART receiver and the PS/2 serialiser.
module ascii2ps2_seq #(
    parameter int FIFO_DEPTH = 32,
    parameter bit HOLD_SHIFT = 1'b0,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input logic            clk,
    input logic            rst,
    ascii2ps2_seq_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SH_BRK_F0 = 4'd1,
        S_SH_BRK    = 4'd2,
        S_SH_MAKE   = 4'd3,
        S_PFX_M     = 4'd4,
        S_MAKE      = 4'd5,
        S_PFX_B     = 4'd6,
        S_BRK_F0    = 4'd7,
        S_BRK       = 4'd8,
        S_SH_REL_F0 = 4'd9,
        S_SH_REL    = 4'd10
    } state_t;

    localparam logic [AW+1:0] C_DEPTH    = (AW+2)'(FIFO_DEPTH);
    localparam logic [AW+1:0] C_MIN_FREE = (AW+2)'(7);

    // Scancode translator: returns {shift, set-2 code}; code 0x00 means no key.
    function automatic logic [8:0] f_translate(input logic [7:0] a);
        logic [7:0] k;
        logic [7:0] c;
        logic       sh;
        sh = 1'b0;
        k  = a;
        c  = 8'h00;
        if (a >= 8'h41 && a <= 8'h5A) begin
            sh = 1'b1;
            k  = a | 8'h20;
        end
        case (k)
            8'h61: c = 8'h1C;  8'h62: c = 8'h32;  8'h63: c = 8'h21;  8'h64: c = 8'h23;
            8'h65: c = 8'h24;  8'h66: c = 8'h2B;  8'h67: c = 8'h34;  8'h68: c = 8'h33;
            8'h69: c = 8'h43;  8'h6A: c = 8'h3B;  8'h6B: c = 8'h42;  8'h6C: c = 8'h4B;
            8'h6D: c = 8'h3A;  8'h6E: c = 8'h31;  8'h6F: c = 8'h44;  8'h70: c = 8'h4D;
            8'h71: c = 8'h15;  8'h72: c = 8'h2D;  8'h73: c = 8'h1B;  8'h74: c = 8'h2C;
            8'h75: c = 8'h3C;  8'h76: c = 8'h2A;  8'h77: c = 8'h1D;  8'h78: c = 8'h22;
            8'h79: c = 8'h35;  8'h7A: c = 8'h1A;
            8'h30: c = 8'h45;  8'h31: c = 8'h16;  8'h32: c = 8'h1E;  8'h33: c = 8'h26;
            8'h34: c = 8'h25;  8'h35: c = 8'h2E;  8'h36: c = 8'h36;  8'h37: c = 8'h3D;
            8'h38: c = 8'h3E;  8'h39: c = 8'h46;
            8'h2D: c = 8'h4E;  8'h3D: c = 8'h55;  8'h2C: c = 8'h41;  8'h2E: c = 8'h49;
            8'h2F: c = 8'h4A;
            8'h5F: begin c = 8'h4E; sh = 1'b1; end
            8'h2B: begin c = 8'h55; sh = 1'b1; end
            8'h3C: begin c = 8'h41; sh = 1'b1; end
            8'h3E: begin c = 8'h49; sh = 1'b1; end
            8'h3F: begin c = 8'h4A; sh = 1'b1; end
            8'h20: c = 8'h29;  8'h0D: c = 8'h5A;  8'h08: c = 8'h66;  8'h09: c = 8'h0D;
            8'h1B: c = 8'h76;
            default: c = 8'h00;
        endcase
        return {sh, c};
    endfunction

    // Next state = lowest planned state above the current one, else IDLE.
    function automatic state_t f_next(input logic [10:1] plan, input logic [3:0] cur);
        state_t nxt;
        nxt = S_IDLE;
        for (int i = 10; i >= 1; i--) begin
            if (plan[i] && (4'(i) > cur)) nxt = state_t'(4'(i));
        end
        return nxt;
    endfunction

    state_t        r_state;
    logic [7:0]    r_code;
    logic [10:1]   r_plan;
    logic          r_shift_held;
    logic          r_overflow;
    logic          r_valid;
    logic [7:0]    r_scancode;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [7:0]    r_mem [FIFO_DEPTH];

    logic [8:0]    w_tr;
    logic          w_ext;
    logic          w_shift;
    logic          w_char_ok;
    logic          w_sh_make;
    logic          w_sh_brk;
    logic          w_sh_rel;
    logic [7:0]    w_ovr;
    logic [7:0]    w_code;
    logic [10:1]   w_plan;
    logic [7:0]    w_wr_data;
    logic [AW+1:0] w_free;
    logic          w_in_ready;
    logic          w_wr;
    logic          w_rd;

    always_comb begin
        w_tr  = f_translate(bus.ascii);
        w_ext = (bus.ascii[7:2] == 6'b100000);
        case (bus.ascii[1:0])
            2'd0:    w_ovr = 8'h75;
            2'd1:    w_ovr = 8'h72;
            2'd2:    w_ovr = 8'h6B;
            default: w_ovr = 8'h74;
        endcase
        w_code    = w_ext ? w_ovr : w_tr[7:0];
        w_shift   = !w_ext && w_tr[8];
        w_char_ok = w_ext || (w_tr[7:0] != 8'h00);
        if (HOLD_SHIFT) begin
            w_sh_make = w_shift && !r_shift_held;
            w_sh_brk  = !w_ext && !w_shift && r_shift_held;
            w_sh_rel  = 1'b0;
        end else begin
            w_sh_make = w_shift;
            w_sh_brk  = 1'b0;
            w_sh_rel  = w_shift;
        end
        // One bit per writer state, bit index equals the state encoding.
        w_plan = {w_sh_rel, w_sh_rel, 1'b1, 1'b1, w_ext, 1'b1, w_ext, w_sh_make, w_sh_brk, w_sh_brk};
    end

    always_comb begin
        w_wr_data = 8'h00;
        case (r_state)
            S_SH_BRK_F0, S_BRK_F0, S_SH_REL_F0: w_wr_data = 8'hF0;
            S_SH_BRK, S_SH_MAKE, S_SH_REL:      w_wr_data = 8'h12;
            S_PFX_M, S_PFX_B:                   w_wr_data = 8'hE0;
            S_MAKE, S_BRK:                      w_wr_data = r_code;
            default:                            w_wr_data = 8'h00;
        endcase
    end

    // Seven free entries cover the longest six-byte sequence with margin.
    assign w_free     = C_DEPTH - {1'b0, r_level};
    assign w_in_ready = (r_state == S_IDLE) && (w_free >= C_MIN_FREE);
    assign w_wr       = (r_state != S_IDLE);
    assign w_rd       = (!r_valid || bus.ready) && (r_level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_code       <= 8'h00;
            r_plan       <= '0;
            r_shift_held <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (bus.latch && !w_in_ready) r_overflow <= 1'b1;
            if (r_state == S_IDLE) begin
                if (bus.latch && w_in_ready && w_char_ok) begin
                    r_code  <= w_code;
                    r_plan  <= w_plan;
                    r_state <= f_next(w_plan, 4'd0);
                end
            end else begin
                r_state <= f_next(r_plan, r_state);
                if (r_state == S_SH_MAKE) r_shift_held <= 1'b1;
                if (r_state == S_SH_BRK || r_state == S_SH_REL) r_shift_held <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_scancode <= 8'h00;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) begin
                r_rptr     <= r_rptr + AW'(1);
                r_scancode <= r_mem[r_rptr];
                r_valid    <= 1'b1;
            end else if (bus.ready) begin
                r_valid <= 1'b0;
            end
            if (w_wr && !w_rd) r_level <= r_level + (AW+1)'(1);
            else if (!w_wr && w_rd) r_level <= r_level - (AW+1)'(1);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.scancode   = r_scancode;
    assign bus.valid      = r_valid;
    assign bus.shift_held = r_shift_held;
    assign bus.overflow   = r_overflow;
    assign bus.level      = r_level;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_ascii2ps2_seq.sv
// Bench for ascii2ps2_seq: three configurations, a key-event reference model feeding
// per-instance expected queues, and a monitor that checks every presented byte.
module tb_ascii2ps2_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ascii2ps2_seq_if #(.FIFO_DEPTH(32)) if0 ();
    ascii2ps2_seq_if #(.FIFO_DEPTH(16)) if1 ();
    ascii2ps2_seq_if #(.FIFO_DEPTH(8))  if2 ();

    ascii2ps2_seq #(.FIFO_DEPTH(32), .HOLD_SHIFT(1'b0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    ascii2ps2_seq #(.FIFO_DEPTH(16), .HOLD_SHIFT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    ascii2ps2_seq #(.FIFO_DEPTH(8),  .HOLD_SHIFT(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    logic [7:0] ascii_d [3];
    logic       latch_d [3];
    logic       ready_d [3];
    logic       in_ready_s [3];
    logic       valid_s [3];
    logic       held_s [3];
    logic       ovf_s [3];
    logic [7:0] sc_s [3];
    logic [7:0] lvl_s [3];

    assign if0.ascii = ascii_d[0];  assign if0.latch = latch_d[0];  assign if0.ready = ready_d[0];
    assign if1.ascii = ascii_d[1];  assign if1.latch = latch_d[1];  assign if1.ready = ready_d[1];
    assign if2.ascii = ascii_d[2];  assign if2.latch = latch_d[2];  assign if2.ready = ready_d[2];
    assign in_ready_s[0] = if0.in_ready;  assign in_ready_s[1] = if1.in_ready;  assign in_ready_s[2] = if2.in_ready;
    assign valid_s[0]    = if0.valid;     assign valid_s[1]    = if1.valid;     assign valid_s[2]    = if2.valid;
    assign held_s[0]     = if0.shift_held; assign held_s[1]    = if1.shift_held; assign held_s[2]    = if2.shift_held;
    assign ovf_s[0]      = if0.overflow;  assign ovf_s[1]      = if1.overflow;  assign ovf_s[2]      = if2.overflow;
    assign sc_s[0]       = if0.scancode;  assign sc_s[1]       = if1.scancode;  assign sc_s[2]       = if2.scancode;
    assign lvl_s[0]      = 8'(if0.level); assign lvl_s[1]      = 8'(if1.level); assign lvl_s[2]      = 8'(if2.level);

    // Reference model state
    logic [8:0] tbl [256];
    logic [7:0] ovr [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    int         hold_of [3] = '{0, 0, 1};
    bit         model_held [3];
    bit         exp_ovf [3];
    int         n_pop [3];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q2 [$];
    string      s_punct = "-=,./_+<>?";

    int n_vec = 0;
    int n_err = 0;

    task automatic build_tbl();
        string      s_lc = "abcdefghijklmnopqrstuvwxyz";
        string      s_dg = "0123456789";
        string      s_pu = "-=,./";
        string      s_ps = "_+<>?";
        logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] pun_sc [5]  = '{8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A};
        for (int i = 0; i < 256; i++) tbl[i] = 9'h000;
        for (int i = 0; i < 26; i++) begin
            tbl[8'(s_lc[i])]          = {1'b0, let_sc[i]};
            tbl[8'(s_lc[i]) - 8'h20]  = {1'b1, let_sc[i]};
        end
        for (int i = 0; i < 10; i++) tbl[8'(s_dg[i])] = {1'b0, dig_sc[i]};
        for (int i = 0; i < 5; i++) begin
            tbl[8'(s_pu[i])] = {1'b0, pun_sc[i]};
            tbl[8'(s_ps[i])] = {1'b1, pun_sc[i]};
        end
        tbl[8'h20] = 9'h029;  tbl[8'h0D] = 9'h05A;  tbl[8'h08] = 9'h066;
        tbl[8'h09] = 9'h00D;  tbl[8'h1B] = 9'h076;
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic void qpush(input int k, input logic [7:0] b);
        case (k)
            0:       exp_q0.push_back(b);
            1:       exp_q1.push_back(b);
            default: exp_q2.push_back(b);
        endcase
    endfunction

    function automatic logic [7:0] qpop(input int k);
        case (k)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    function automatic logic [7:0] qpeek(input int k);
        case (k)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    // Key-level model: a press emits the code, a release emits F0 then the code.
    task automatic model_char(input int k, input logic [7:0] a);
        logic [7:0] c;
        bit         sh;
        if (a >= 8'h80 && a <= 8'h83) begin
            c = ovr[a[1:0]];
            qpush(k, 8'hE0); qpush(k, c);
            qpush(k, 8'hE0); qpush(k, 8'hF0); qpush(k, c);
            return;
        end
        c  = tbl[a][7:0];
        sh = tbl[a][8];
        if (c == 8'h00) return;
        if (hold_of[k] != 0) begin
            if (sh && !model_held[k]) begin
                qpush(k, 8'h12);
                model_held[k] = 1'b1;
            end else if (!sh && model_held[k]) begin
                qpush(k, 8'hF0); qpush(k, 8'h12);
                model_held[k] = 1'b0;
            end
        end else if (sh) begin
            qpush(k, 8'h12);
        end
        qpush(k, c); qpush(k, 8'hF0); qpush(k, c);
        if (hold_of[k] == 0 && sh) begin
            qpush(k, 8'hF0); qpush(k, 8'h12);
        end
    endtask

    task automatic check_bit(input string name, input int k, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %b required %b", name, k, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d: got %02h required %02h", name, k, act, exp);
        end
    endtask

    // Monitor: a presented byte must be the queue head; it is consumed when ready is high.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 3; k++) begin
                if (valid_s[k] === 1'b1) begin
                    if (qsize(k) == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte inst%0d: got %02h required no byte", k, sc_s[k]);
                    end else if (ready_d[k] === 1'b1) begin
                        check_byte("byte", k, sc_s[k], qpop(k));
                        n_pop[k]++;
                    end else begin
                        check_byte("stalled_byte", k, sc_s[k], qpeek(k));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] a);
        int guard;
        guard = 0;
        while (in_ready_s[k] !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (in_ready_s[k] !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL in_ready_timeout inst%0d: got %b required 1", k, in_ready_s[k]);
        end else begin
            ascii_d[k] = a;
            latch_d[k] = 1'b1;
            model_char(k, a);
            tick();
            latch_d[k] = 1'b0;
        end
    endtask

    task automatic drain(input int k);
        int guard;
        guard = 0;
        ready_d[k] = 1'b1;
        while (!(qsize(k) == 0 && valid_s[k] === 1'b0 && lvl_s[k] == 8'h00 && in_ready_s[k] === 1'b1)
               && guard < 600) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard >= 600) begin
            n_err++;
            $display("FAIL drain_timeout inst%0d: got %0d bytes still expected, required 0", k, qsize(k));
        end
    endtask

    task automatic check_reset(input int k);
        check_bit("rst_valid", k, valid_s[k], 1'b0);
        check_byte("rst_scancode", k, sc_s[k], 8'h00);
        check_byte("rst_level", k, lvl_s[k], 8'h00);
        check_bit("rst_overflow", k, ovf_s[k], 1'b0);
        check_bit("rst_shift_held", k, held_s[k], 1'b0);
        check_bit("rst_in_ready", k, in_ready_s[k], 1'b1);
    endtask

    function automatic logic [7:0] pick_char();
        case ($urandom_range(0, 6))
            0, 1:    return 8'(32'h61 + $urandom_range(0, 25));
            2:       return 8'(32'h41 + $urandom_range(0, 25));
            3:       return 8'(32'h30 + $urandom_range(0, 9));
            4:       return 8'(32'h80 + $urandom_range(0, 3));
            5:       return 8'(s_punct[$urandom_range(0, 9)]);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pops0;
        build_tbl();
        for (int k = 0; k < 3; k++) begin
            ascii_d[k] = 8'h00; latch_d[k] = 1'b0; ready_d[k] = 1'b1;
            model_held[k] = 1'b0; exp_ovf[k] = 1'b0; n_pop[k] = 0;
        end
        rst = 1'b1;
        tick(); tick();
        for (int k = 0; k < 3; k++) check_reset(k);
        rst = 1'b0;
        tick();

        // 'a' on the 32-deep, non-holding encoder: latency and in_ready recovery
        ascii_d[0] = 8'h61; latch_d[0] = 1'b1; model_char(0, 8'h61);
        tick();
        latch_d[0] = 1'b0;
        check_bit("lat_valid_e0", 0, valid_s[0], 1'b0);
        check_bit("lat_inrdy_e0", 0, in_ready_s[0], 1'b0);
        tick();
        check_bit("lat_valid_e1", 0, valid_s[0], 1'b0);
        check_bit("lat_inrdy_e1", 0, in_ready_s[0], 1'b0);
        tick();
        check_bit("lat_valid_e2", 0, valid_s[0], 1'b1);
        check_byte("lat_first_byte", 0, sc_s[0], 8'h1C);
        check_bit("lat_inrdy_e2", 0, in_ready_s[0], 1'b0);
        tick();
        check_bit("lat_inrdy_e3", 0, in_ready_s[0], 1'b1);
        drain(0);

        send(0, 8'h41);
        drain(0);
        check_bit("held_after_A", 0, held_s[0], 1'b0);

        // Held shift across "AB", then released before 'c'
        send(2, 8'h41);
        send(2, 8'h42);
        drain(2);
        check_bit("held_after_AB", 2, held_s[2], 1'b1);
        send(2, 8'h63);
        drain(2);
        check_bit("held_after_c", 2, held_s[2], 1'b0);

        // Extended cursor key, then an unmapped byte
        send(0, 8'h80);
        drain(0);
        send(0, 8'h01);
        check_bit("unmapped_inrdy", 0, in_ready_s[0], 1'b1);
        tick(); tick(); tick();
        check_byte("unmapped_level", 0, lvl_s[0], 8'h00);
        check_bit("unmapped_valid", 0, valid_s[0], 1'b0);

        // 16-deep FIFO stalled downstream: fill, overflow, release
        ready_d[1] = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            if (in_ready_s[1] === 1'b1) begin
                ascii_d[1] = 8'h41; latch_d[1] = 1'b1; model_char(1, 8'h41);
                acc++;
            end
            tick();
            latch_d[1] = 1'b0;
        end
        check_byte("fill_accepted", 1, 8'(acc), 8'd2);
        check_byte("fill_level", 1, lvl_s[1], 8'd11);
        check_bit("fill_valid", 1, valid_s[1], 1'b1);
        check_bit("fill_inrdy", 1, in_ready_s[1], 1'b0);
        check_bit("fill_no_ovf", 1, ovf_s[1], 1'b0);
        ascii_d[1] = 8'h7A; latch_d[1] = 1'b1; exp_ovf[1] = 1'b1;
        tick();
        latch_d[1] = 1'b0;
        check_bit("overflow_set", 1, ovf_s[1], 1'b1);
        pops0 = n_pop[1];
        drain(1);
        check_byte("release_count", 1, 8'(n_pop[1] - pops0), 8'd12);
        check_bit("overflow_sticky", 1, ovf_s[1], 1'b1);

        // Reset in the middle of 'A' once 12 and 1C are written
        ready_d[0] = 1'b0;
        send(0, 8'h41);
        acc = 0;
        while ((lvl_s[0] + 8'(valid_s[0])) < 8'd2 && acc < 20) begin
            tick();
            acc++;
        end
        check_byte("pre_rst_outstanding", 0, lvl_s[0] + 8'(valid_s[0]), 8'd2);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check_reset(k);
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        for (int k = 0; k < 3; k++) begin
            model_held[k] = 1'b0;
            exp_ovf[k] = 1'b0;
        end
        tick();
        rst = 1'b0;
        ready_d[0] = 1'b1;
        tick();
        send(0, 8'h61);
        drain(0);
        for (int i = 0; i < 20; i++) send(0, 8'h61);
        drain(0);

        // Randomised characters with random downstream stalls on every configuration
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 400; it++) begin
                logic [7:0] a;
                ready_d[k] = ($urandom_range(0, 3) != 0);
                if (in_ready_s[k] === 1'b1 && $urandom_range(0, 1) == 1) begin
                    a = pick_char();
                    ascii_d[k] = a; latch_d[k] = 1'b1;
                    model_char(k, a);
                end else if (in_ready_s[k] === 1'b0 && $urandom_range(0, 19) == 0) begin
                    ascii_d[k] = 8'h61; latch_d[k] = 1'b1;
                    exp_ovf[k] = 1'b1;
                end
                tick();
                latch_d[k] = 1'b0;
            end
            drain(k);
            check_bit("rand_shift_held", k, held_s[k], model_held[k]);
            check_bit("rand_overflow", k, ovf_s[k], exp_ovf[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
